// File: rtl/add_rs_cdb_listener.sv
// Three-entry adder reservation station that snoops the common data bus.
// Optional oldest-first dispatch is enabled by defining RS_AGE_PRIORITY_EN.
module add_rs_cdb_listener #(
  parameter int          NUM_ENTRIES = 3,
  parameter logic [3:0]  RS_TAG_BASE = 4'd1,
  parameter int          OP_W        = 3
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            issue_valid,
  output logic            issue_ready,
  input  logic [OP_W-1:0] issue_op,
  input  logic [31:0]     issue_vj,
  input  logic [31:0]     issue_vk,
  input  logic [3:0]      issue_qj,
  input  logic [3:0]      issue_qk,
  output logic [3:0]      issue_tag,
  input  logic [31:0]     cdb_data,
  input  logic [3:0]      cdb_tag,
  input  logic            cdb_valid,
  output logic            dispatch_valid,
  input  logic            dispatch_ready,
  output logic [OP_W-1:0] dispatch_op,
  output logic [31:0]     dispatch_a,
  output logic [31:0]     dispatch_b,
  output logic [3:0]      dispatch_tag,
  output logic [3:0]      busy_count
);

  localparam int IDX_W = 3;

  typedef enum logic [1:0] {ST_FREE, ST_WAIT, ST_READY, ST_EXEC} ent_state_t;

  ent_state_t      state_q [NUM_ENTRIES];
  logic [OP_W-1:0] op_q    [NUM_ENTRIES];
  logic [31:0]     vj_q    [NUM_ENTRIES];
  logic [31:0]     vk_q    [NUM_ENTRIES];
  logic [3:0]      qj_q    [NUM_ENTRIES];
  logic [3:0]      qk_q    [NUM_ENTRIES];

  logic                   cdb_hit;
  logic                   free_found;
  logic [IDX_W-1:0]       free_idx;
  logic [3:0]             busy;
  logic [NUM_ENTRIES-1:0] rel;
  logic                   rel_any;
  logic [NUM_ENTRIES-1:0] hit_j;
  logic [NUM_ENTRIES-1:0] hit_k;

  logic                   sel_found;
  logic [IDX_W-1:0]       sel_idx;
  logic [OP_W-1:0]        sel_op;
  logic [31:0]            sel_a;
  logic [31:0]            sel_b;
  logic                   better;

  logic                   alloc_fire;
  logic                   disp_fire;
  logic [3:0]             byp_qj;
  logic [3:0]             byp_qk;
  logic [31:0]            byp_vj;
  logic [31:0]            byp_vk;

`ifdef RS_AGE_PRIORITY_EN
  logic [IDX_W-1:0]       age_q [NUM_ENTRIES];
  logic [IDX_W-1:0]       rel_age;
  logic [IDX_W-1:0]       best_age;
  logic [IDX_W-1:0]       alloc_age;
`endif

  function automatic logic [3:0] tag_of(input int idx);
    return RS_TAG_BASE + 4'(idx);
  endfunction

  // Tag 0 means "value present", so a zero-tag broadcast never matches anything.
  assign cdb_hit = cdb_valid && (cdb_tag != 4'd0);

  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    busy       = '0;
    rel        = '0;
    rel_any    = 1'b0;
    hit_j      = '0;
    hit_k      = '0;
`ifdef RS_AGE_PRIORITY_EN
    rel_age    = '0;
`endif
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (state_q[i] == ST_FREE) begin
        if (!free_found) begin
          free_found = 1'b1;
          free_idx   = IDX_W'(i);
        end
      end else begin
        busy = busy + 4'd1;
      end
      if (state_q[i] == ST_EXEC && cdb_hit && cdb_tag == tag_of(i)) begin
        rel[i]  = 1'b1;
        rel_any = 1'b1;
`ifdef RS_AGE_PRIORITY_EN
        rel_age = age_q[i];
`endif
      end
      hit_j[i] = cdb_hit && (qj_q[i] == cdb_tag);
      hit_k[i] = cdb_hit && (qk_q[i] == cdb_tag);
    end
  end

  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    sel_op    = '0;
    sel_a     = '0;
    sel_b     = '0;
    better    = 1'b0;
`ifdef RS_AGE_PRIORITY_EN
    best_age  = '1;
`endif
    for (int i = 0; i < NUM_ENTRIES; i++) begin
`ifdef RS_AGE_PRIORITY_EN
      better = !sel_found || (age_q[i] < best_age);
`else
      better = !sel_found;
`endif
      if (state_q[i] == ST_READY && better) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(i);
        sel_op    = op_q[i];
        sel_a     = vj_q[i];
        sel_b     = vk_q[i];
`ifdef RS_AGE_PRIORITY_EN
        best_age  = age_q[i];
`endif
      end
    end
  end

  assign issue_ready    = free_found;
  assign issue_tag      = RS_TAG_BASE + 4'(free_idx);
  assign busy_count     = busy;
  assign dispatch_valid = sel_found;
  assign dispatch_op    = sel_op;
  assign dispatch_a     = sel_a;
  assign dispatch_b     = sel_b;
  assign dispatch_tag   = sel_found ? (RS_TAG_BASE + 4'(sel_idx)) : 4'd0;

  assign alloc_fire = issue_valid && free_found;
  assign disp_fire  = sel_found && dispatch_ready;

  // An issue that names the tag being broadcast this cycle takes the value directly.
  assign byp_qj = (cdb_hit && issue_qj == cdb_tag) ? 4'd0     : issue_qj;
  assign byp_vj = (cdb_hit && issue_qj == cdb_tag) ? cdb_data : issue_vj;
  assign byp_qk = (cdb_hit && issue_qk == cdb_tag) ? 4'd0     : issue_qk;
  assign byp_vk = (cdb_hit && issue_qk == cdb_tag) ? cdb_data : issue_vk;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        state_q[i] <= ST_FREE;
        op_q[i]    <= '0;
        vj_q[i]    <= '0;
        vk_q[i]    <= '0;
        qj_q[i]    <= '0;
        qk_q[i]    <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        case (state_q[i])
          ST_FREE: begin
            if (alloc_fire && free_idx == IDX_W'(i)) begin
              op_q[i]    <= issue_op;
              vj_q[i]    <= byp_vj;
              vk_q[i]    <= byp_vk;
              qj_q[i]    <= byp_qj;
              qk_q[i]    <= byp_qk;
              state_q[i] <= (byp_qj == 4'd0 && byp_qk == 4'd0) ? ST_READY : ST_WAIT;
            end
          end
          ST_WAIT: begin
            if (hit_j[i]) begin
              qj_q[i] <= 4'd0;
              vj_q[i] <= cdb_data;
            end
            if (hit_k[i]) begin
              qk_q[i] <= 4'd0;
              vk_q[i] <= cdb_data;
            end
            if ((qj_q[i] == 4'd0 || hit_j[i]) && (qk_q[i] == 4'd0 || hit_k[i]))
              state_q[i] <= ST_READY;
          end
          ST_READY: begin
            if (disp_fire && sel_idx == IDX_W'(i))
              state_q[i] <= ST_EXEC;
          end
          ST_EXEC: begin
            if (rel[i])
              state_q[i] <= ST_FREE;
          end
          default: state_q[i] <= ST_FREE;
        endcase
      end
    end
  end

`ifdef RS_AGE_PRIORITY_EN
  // Age counts the live entries issued earlier; a release closes the gap it leaves.
  assign alloc_age = IDX_W'(busy - {3'b000, rel_any});

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_ENTRIES; i++)
        age_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        if (alloc_fire && free_idx == IDX_W'(i))
          age_q[i] <= alloc_age;
        else if (rel_any && state_q[i] != ST_FREE && !rel[i] && age_q[i] > rel_age)
          age_q[i] <= age_q[i] - 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_add_rs_cdb_listener.sv
// Directed self-checking bench for add_rs_cdb_listener (default or RS_AGE_PRIORITY_EN build).
module tb_add_rs_cdb_listener;

  logic        clk;
  logic        reset_n;
  logic        issue_valid;
  logic        issue_ready;
  logic [2:0]  issue_op;
  logic [31:0] issue_vj;
  logic [31:0] issue_vk;
  logic [3:0]  issue_qj;
  logic [3:0]  issue_qk;
  logic [3:0]  issue_tag;
  logic [31:0] cdb_data;
  logic [3:0]  cdb_tag;
  logic        cdb_valid;
  logic        dispatch_valid;
  logic        dispatch_ready;
  logic [2:0]  dispatch_op;
  logic [31:0] dispatch_a;
  logic [31:0] dispatch_b;
  logic [3:0]  dispatch_tag;
  logic [3:0]  busy_count;

  int n_checks;
  int n_fail;

  add_rs_cdb_listener dut (
    .clk(clk), .reset_n(reset_n),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_op(issue_op),
    .issue_vj(issue_vj), .issue_vk(issue_vk), .issue_qj(issue_qj), .issue_qk(issue_qk),
    .issue_tag(issue_tag),
    .cdb_data(cdb_data), .cdb_tag(cdb_tag), .cdb_valid(cdb_valid),
    .dispatch_valid(dispatch_valid), .dispatch_ready(dispatch_ready),
    .dispatch_op(dispatch_op), .dispatch_a(dispatch_a), .dispatch_b(dispatch_b),
    .dispatch_tag(dispatch_tag), .busy_count(busy_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  // Inputs change 1 ns after the rising edge; outputs are sampled there too.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    issue_valid = 0; issue_op = 0; issue_vj = 0; issue_vk = 0; issue_qj = 0; issue_qk = 0;
    cdb_valid = 0; cdb_tag = 0; cdb_data = 0; dispatch_ready = 0;
  endtask

  task automatic set_issue(input logic [2:0] op, input logic [31:0] vj, input logic [31:0] vk,
                           input logic [3:0] qj, input logic [3:0] qk);
    issue_valid = 1; issue_op = op; issue_vj = vj; issue_vk = vk; issue_qj = qj; issue_qk = qk;
  endtask

  task automatic broadcast(input logic [3:0] tag, input logic [31:0] data);
    cdb_valid = 1; cdb_tag = tag; cdb_data = data;
    tick;
    cdb_valid = 0; cdb_tag = 0; cdb_data = 0;
  endtask

  task automatic test_reset;
    reset_n = 0;
    idle_inputs;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (issue_ready !== 1'b1) begin $display("[TB] FAIL rst_issue_ready got %0b want 1", issue_ready); n_fail++; end
    n_checks++; if (issue_tag !== 4'd1) begin $display("[TB] FAIL rst_issue_tag got %0d want 1", issue_tag); n_fail++; end
    n_checks++; if (busy_count !== 4'd0) begin $display("[TB] FAIL rst_busy got %0d want 0", busy_count); n_fail++; end
    n_checks++; if (dispatch_valid !== 1'b0) begin $display("[TB] FAIL rst_dv got %0b want 0", dispatch_valid); n_fail++; end
    n_checks++; if (dispatch_a !== 32'd0 || dispatch_b !== 32'd0 || dispatch_op !== 3'd0 || dispatch_tag !== 4'd0)
      begin $display("[TB] FAIL rst_dispatch_data got a=%h b=%h op=%0d tag=%0d want all 0", dispatch_a, dispatch_b, dispatch_op, dispatch_tag); n_fail++; end
    reset_n = 1;
    tick;
  endtask

  task automatic test_direct_issue;
    set_issue(3'd0, 32'd5, 32'd7, 4'd0, 4'd0);
    dispatch_ready = 1;
    tick;
    issue_valid = 0;
    n_checks++; if (dispatch_valid !== 1'b1) begin $display("[TB] FAIL direct_dv got %0b want 1", dispatch_valid); n_fail++; end
    n_checks++; if (dispatch_a !== 32'd5 || dispatch_b !== 32'd7) begin $display("[TB] FAIL direct_ab got %0d/%0d want 5/7", dispatch_a, dispatch_b); n_fail++; end
    n_checks++; if (dispatch_tag !== 4'd1) begin $display("[TB] FAIL direct_tag got %0d want 1", dispatch_tag); n_fail++; end
    tick;
    dispatch_ready = 0;
    n_checks++; if (dispatch_valid !== 1'b0) begin $display("[TB] FAIL direct_exec_dv got %0b want 0", dispatch_valid); n_fail++; end
    n_checks++; if (busy_count !== 4'd1) begin $display("[TB] FAIL direct_busy got %0d want 1", busy_count); n_fail++; end
    n_checks++; if (issue_tag !== 4'd2) begin $display("[TB] FAIL direct_issue_tag got %0d want 2", issue_tag); n_fail++; end
    broadcast(4'd1, 32'h0);
    n_checks++; if (busy_count !== 4'd0 || issue_tag !== 4'd1) begin $display("[TB] FAIL direct_release got busy=%0d tag=%0d want 0/1", busy_count, issue_tag); n_fail++; end
  endtask

  task automatic test_snoop;
    set_issue(3'd1, 32'h99, 32'd3, 4'd4, 4'd0);
    tick;
    issue_valid = 0;
    n_checks++; if (dispatch_valid !== 1'b0) begin $display("[TB] FAIL snoop_wait_dv got %0b want 0", dispatch_valid); n_fail++; end
    broadcast(4'd0, 32'h55);
    n_checks++; if (dispatch_valid !== 1'b0) begin $display("[TB] FAIL snoop_tag0_dv got %0b want 0", dispatch_valid); n_fail++; end
    broadcast(4'd1, 32'h66);
    n_checks++; if (dispatch_valid !== 1'b0 || busy_count !== 4'd1) begin $display("[TB] FAIL snoop_owntag got dv=%0b busy=%0d want 0/1", dispatch_valid, busy_count); n_fail++; end
    broadcast(4'd4, 32'h10);
    n_checks++; if (dispatch_valid !== 1'b1) begin $display("[TB] FAIL snoop_dv got %0b want 1", dispatch_valid); n_fail++; end
    n_checks++; if (dispatch_a !== 32'h10 || dispatch_b !== 32'd3 || dispatch_op !== 3'd1)
      begin $display("[TB] FAIL snoop_data got a=%h b=%h op=%0d want 10/3/1", dispatch_a, dispatch_b, dispatch_op); n_fail++; end
    dispatch_ready = 1;
    tick;
    dispatch_ready = 0;
    broadcast(4'd1, 32'h0);
    n_checks++; if (busy_count !== 4'd0) begin $display("[TB] FAIL snoop_cleanup_busy got %0d want 0", busy_count); n_fail++; end
  endtask

  task automatic test_dual_match;
    set_issue(3'd3, 32'h0, 32'h0, 4'd5, 4'd5);
    tick;
    issue_valid = 0;
    broadcast(4'd5, 32'h7);
    n_checks++; if (dispatch_valid !== 1'b1 || dispatch_a !== 32'h7 || dispatch_b !== 32'h7)
      begin $display("[TB] FAIL dual_match got dv=%0b a=%h b=%h want 1/7/7", dispatch_valid, dispatch_a, dispatch_b); n_fail++; end
    dispatch_ready = 1;
    tick;
    dispatch_ready = 0;
    broadcast(4'd1, 32'h0);
  endtask

  task automatic test_bypass;
    set_issue(3'd2, 32'h0, 32'd1, 4'd4, 4'd0);
    cdb_valid = 1; cdb_tag = 4'd4; cdb_data = 32'h22;
    tick;
    idle_inputs;
    n_checks++; if (dispatch_valid !== 1'b1 || dispatch_a !== 32'h22 || dispatch_b !== 32'd1)
      begin $display("[TB] FAIL bypass got dv=%0b a=%h b=%h want 1/22/1", dispatch_valid, dispatch_a, dispatch_b); n_fail++; end
    dispatch_ready = 1;
    tick;
    dispatch_ready = 0;
    broadcast(4'd1, 32'h0);
    n_checks++; if (busy_count !== 4'd0) begin $display("[TB] FAIL bypass_cleanup_busy got %0d want 0", busy_count); n_fail++; end
  endtask

  task automatic test_full_release;
    for (int i = 0; i < 3; i++) begin
      set_issue(3'd0, 32'(i + 1), 32'd0, 4'd0, 4'd0);
      tick;
    end
    issue_valid = 0;
    n_checks++; if (issue_ready !== 1'b0 || busy_count !== 4'd3) begin $display("[TB] FAIL full got ready=%0b busy=%0d want 0/3", issue_ready, busy_count); n_fail++; end
    set_issue(3'd0, 32'hdead, 32'd0, 4'd0, 4'd0);
    tick;
    issue_valid = 0;
    n_checks++; if (busy_count !== 4'd3 || dispatch_tag !== 4'd1 || dispatch_a !== 32'd1)
      begin $display("[TB] FAIL full_ignore got busy=%0d tag=%0d a=%h want 3/1/1", busy_count, dispatch_tag, dispatch_a); n_fail++; end
    dispatch_ready = 1;
    tick;
    dispatch_ready = 0;
    n_checks++; if (dispatch_tag !== 4'd2) begin $display("[TB] FAIL full_next_tag got %0d want 2", dispatch_tag); n_fail++; end
    broadcast(4'd1, 32'h0);
    n_checks++; if (issue_ready !== 1'b1 || issue_tag !== 4'd1 || busy_count !== 4'd2)
      begin $display("[TB] FAIL full_release got ready=%0b tag=%0d busy=%0d want 1/1/2", issue_ready, issue_tag, busy_count); n_fail++; end
    dispatch_ready = 1;
    tick; tick;
    dispatch_ready = 0;
    broadcast(4'd2, 32'h0);
    broadcast(4'd3, 32'h0);
    n_checks++; if (busy_count !== 4'd0) begin $display("[TB] FAIL full_cleanup_busy got %0d want 0", busy_count); n_fail++; end
  endtask

  task automatic test_simultaneous;
    set_issue(3'd0, 32'd1, 32'd1, 4'd0, 4'd0);
    tick;
    set_issue(3'd4, 32'd0, 32'd2, 4'd1, 4'd0);
    tick;
    issue_valid = 0;
    dispatch_ready = 1;
    tick;
    dispatch_ready = 0;
    // Release of entry 0, wakeup of entry 1 and allocation of entry 2 in one edge.
    set_issue(3'd5, 32'd9, 32'd9, 4'd0, 4'd0);
    cdb_valid = 1; cdb_tag = 4'd1; cdb_data = 32'h30;
    tick;
    idle_inputs;
    n_checks++; if (busy_count !== 4'd2 || issue_tag !== 4'd1) begin $display("[TB] FAIL simul_alloc got busy=%0d tag=%0d want 2/1", busy_count, issue_tag); n_fail++; end
    n_checks++; if (dispatch_valid !== 1'b1 || dispatch_tag !== 4'd2 || dispatch_a !== 32'h30 || dispatch_b !== 32'd2)
      begin $display("[TB] FAIL simul_dispatch got dv=%0b tag=%0d a=%h b=%h want 1/2/30/2", dispatch_valid, dispatch_tag, dispatch_a, dispatch_b); n_fail++; end
    dispatch_ready = 1;
    tick;
    n_checks++; if (dispatch_tag !== 4'd3 || dispatch_op !== 3'd5) begin $display("[TB] FAIL simul_third got tag=%0d op=%0d want 3/5", dispatch_tag, dispatch_op); n_fail++; end
    tick;
    dispatch_ready = 0;
    broadcast(4'd2, 32'h0);
    broadcast(4'd3, 32'h0);
    n_checks++; if (busy_count !== 4'd0) begin $display("[TB] FAIL simul_cleanup_busy got %0d want 0", busy_count); n_fail++; end
  endtask

  task automatic test_priority;
    logic [3:0]  exp_tag;
    logic [31:0] exp_a;
`ifdef RS_AGE_PRIORITY_EN
    exp_tag = 4'd2; exp_a = 32'h101;
`else
    exp_tag = 4'd1; exp_a = 32'h200;
`endif
    for (int i = 0; i < 3; i++) begin
      set_issue(3'd0, 32'h100 + 32'(i), 32'd0, 4'd0, 4'd0);
      tick;
    end
    issue_valid = 0;
    n_checks++; if (dispatch_tag !== 4'd1) begin $display("[TB] FAIL prio_first got %0d want 1", dispatch_tag); n_fail++; end
    dispatch_ready = 1;
    tick;
    dispatch_ready = 0;
    broadcast(4'd1, 32'h0);
    n_checks++; if (issue_tag !== 4'd1) begin $display("[TB] FAIL prio_reissue_tag got %0d want 1", issue_tag); n_fail++; end
    set_issue(3'd0, 32'h200, 32'd0, 4'd0, 4'd0);
    tick;
    issue_valid = 0;
    dispatch_ready = 1;
    #1;
    n_checks++; if (dispatch_tag !== exp_tag || dispatch_a !== exp_a)
      begin $display("[TB] FAIL prio_select got tag=%0d a=%h want %0d/%h", dispatch_tag, dispatch_a, exp_tag, exp_a); n_fail++; end
    tick; tick; tick;
    dispatch_ready = 0;
    broadcast(4'd1, 32'h0);
    broadcast(4'd2, 32'h0);
    broadcast(4'd3, 32'h0);
    n_checks++; if (busy_count !== 4'd0) begin $display("[TB] FAIL prio_cleanup_busy got %0d want 0", busy_count); n_fail++; end
  endtask

  task automatic test_reset_mid;
    set_issue(3'd0, 32'd1, 32'd1, 4'd0, 4'd0);
    tick;
    set_issue(3'd0, 32'd0, 32'd1, 4'd4, 4'd0);
    dispatch_ready = 1;
    tick;
    dispatch_ready = 0;
    set_issue(3'd0, 32'd8, 32'd8, 4'd0, 4'd0);
    tick;
    issue_valid = 0;
    n_checks++; if (busy_count !== 4'd3 || dispatch_tag !== 4'd3) begin $display("[TB] FAIL mid_setup got busy=%0d tag=%0d want 3/3", busy_count, dispatch_tag); n_fail++; end
    #2;
    reset_n = 0;
    #1;
    n_checks++; if (dispatch_valid !== 1'b0 || busy_count !== 4'd0 || issue_tag !== 4'd1)
      begin $display("[TB] FAIL mid_async got dv=%0b busy=%0d tag=%0d want 0/0/1", dispatch_valid, busy_count, issue_tag); n_fail++; end
    #2;
    reset_n = 1;
    tick;
    broadcast(4'd4, 32'h44);
    n_checks++; if (dispatch_valid !== 1'b0 || busy_count !== 4'd0)
      begin $display("[TB] FAIL mid_after_cdb got dv=%0b busy=%0d want 0/0", dispatch_valid, busy_count); n_fail++; end
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    test_reset;
    test_direct_issue;
    test_snoop;
    test_dual_match;
    test_bypass;
    test_full_release;
    test_simultaneous;
    test_priority;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
